// File: rtl/s27_multi_pkg.sv
// Shared types and constants for the multi-lane s27 workload.
// Optional scan chain is selected by the SCAN_CHAIN_EN macro in the other files.
package s27_multi_pkg;

    localparam int unsigned S27_STATE_W = 3;

    // Field order gives the STATE bit layout {G7,G6,G5} directly.
    typedef struct packed {
        logic g7;
        logic g6;
        logic g5;
    } lane_state_t;

    localparam lane_state_t LANE_STATE_RST = '0;

endpackage

// File: rtl/s27_multi_if.sv
// Bus bundle for s27_multi: enable, per-lane inputs/outputs, state and counter.
// Scan signals SE/SI/SO exist only when SCAN_CHAIN_EN is defined.
interface s27_multi_if
    import s27_multi_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned CNT_W = 16
);
    logic                         EN;
    logic [LANES-1:0]             G0;
    logic [LANES-1:0]             G1;
    logic [LANES-1:0]             G2;
    logic [LANES-1:0]             G3;
    logic [LANES-1:0]             G17;
    logic [S27_STATE_W*LANES-1:0] STATE;
    logic [CNT_W-1:0]             CYCLES;
`ifdef SCAN_CHAIN_EN
    logic                         SE;
    logic                         SI;
    logic                         SO;

    modport master (
        output EN, G0, G1, G2, G3, SE, SI,
        input  G17, STATE, CYCLES, SO
    );
    modport slave (
        input  EN, G0, G1, G2, G3, SE, SI,
        output G17, STATE, CYCLES, SO
    );
`else
    modport master (
        output EN, G0, G1, G2, G3,
        input  G17, STATE, CYCLES
    );
    modport slave (
        input  EN, G0, G1, G2, G3,
        output G17, STATE, CYCLES
    );
`endif

endinterface

// File: rtl/s27_multi_lane.sv
// One s27 lane: original combinational network plus G5/G6/G7 flops with
// synchronous reset, hold enable and (under SCAN_CHAIN_EN) a scan mux.
module s27_lane
    import s27_multi_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic        i_g0,
    input  logic        i_g1,
    input  logic        i_g2,
    input  logic        i_g3,
`ifdef SCAN_CHAIN_EN
    input  logic        i_se,
    input  logic        i_si,
    output logic        o_so,
`endif
    output logic        o_g17,
    output lane_state_t o_state
);

    lane_state_t r_state;
    lane_state_t w_next;
    logic w_g8, w_g9, w_g10, w_g11, w_g12, w_g13, w_g14, w_g15, w_g16;

    always_comb begin
        w_g14  = ~i_g0;
        w_g12  = ~(i_g1 | r_state.g7);
        w_g8   = w_g14 & r_state.g6;
        w_g15  = w_g12 | w_g8;
        w_g16  = i_g3 | w_g8;
        w_g9   = ~(w_g16 & w_g15);
        w_g11  = ~(r_state.g5 | w_g9);
        w_g10  = ~(w_g14 | w_g11);
        w_g13  = ~(i_g2 | w_g12);
        w_next = '{g7: w_g13, g6: w_g11, g5: w_g10};
    end

    // Priority: reset, then scan shift, then functional advance, else hold.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= LANE_STATE_RST;
        end
`ifdef SCAN_CHAIN_EN
        else if (i_se) begin
            r_state <= '{g7: r_state.g6, g6: r_state.g5, g5: i_si};
        end
`endif
        else if (i_en) begin
            r_state <= w_next;
        end
    end

    assign o_g17   = ~w_g11;
    assign o_state = r_state;
`ifdef SCAN_CHAIN_EN
    assign o_so    = r_state.g7;
`endif

endmodule

// File: rtl/s27_multi.sv
// LANES independent s27 lanes with shared reset/enable and a saturating
// enabled-cycle counter; SCAN_CHAIN_EN daisy-chains lane flops lane0..LANES-1.
module s27_multi
    import s27_multi_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned CNT_W = 16
)(
    input  logic     CK,
    input  logic     RST,
    s27_multi_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cycles;
    logic             w_adv;
    lane_state_t      w_state [LANES];

`ifdef SCAN_CHAIN_EN
    logic [LANES:0]   w_scan;

    assign w_scan[0] = bus.SI;
    assign bus.SO    = w_scan[LANES];
    // A scan shift takes the edge, so it is not a functional cycle.
    assign w_adv     = bus.EN & ~bus.SE;
`else
    assign w_adv     = bus.EN;
`endif

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        s27_lane u_lane (
            .i_clk   (CK),
            .i_rst   (RST),
            .i_en    (bus.EN),
            .i_g0    (bus.G0[gi]),
            .i_g1    (bus.G1[gi]),
            .i_g2    (bus.G2[gi]),
            .i_g3    (bus.G3[gi]),
`ifdef SCAN_CHAIN_EN
            .i_se    (bus.SE),
            .i_si    (w_scan[gi]),
            .o_so    (w_scan[gi+1]),
`endif
            .o_g17   (bus.G17[gi]),
            .o_state (w_state[gi])
        );

        assign bus.STATE[S27_STATE_W*gi +: S27_STATE_W] = w_state[gi];
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            r_cycles <= '0;
        end else if (w_adv && (r_cycles != CNT_MAX)) begin
            r_cycles <= r_cycles + 1'b1;
        end
    end

    assign bus.CYCLES = r_cycles;

endmodule

// File: tb/tb_s27_multi.sv
// Directed and random checks of s27_multi (LANES=4) plus a CNT_W=2 instance
// for counter saturation; scan tests run only when SCAN_CHAIN_EN is defined.
module tb_s27_multi;

    localparam int unsigned LANES = 4;

    logic CK  = 1'b0;
    logic RST = 1'b1;
    logic RST2 = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    s27_multi_if #(.LANES(LANES), .CNT_W(16)) bus  ();
    s27_multi_if #(.LANES(1),     .CNT_W(2))  bus2 ();

    s27_multi #(.LANES(LANES), .CNT_W(16)) dut (
        .CK  (CK),
        .RST (RST),
        .bus (bus)
    );

    s27_multi #(.LANES(1), .CNT_W(2)) dut_sat (
        .CK  (CK),
        .RST (RST2),
        .bus (bus2)
    );

    always #5 CK = ~CK;

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic drive(input logic en, input logic [3:0] g0, input logic [3:0] g1,
                         input logic [3:0] g2, input logic [3:0] g3);
        bus.EN = en;
        bus.G0 = g0;
        bus.G1 = g1;
        bus.G2 = g2;
        bus.G3 = g3;
    endtask

    // Independent reference of one s27 lane; st = {G7,G6,G5}.
    function automatic void ref_s27(input bit a0, input bit a1, input bit a2, input bit a3,
                                    input bit [2:0] st, output bit g17, output bit [2:0] nx);
        bit n8, n9, n10, n11, n12, n13, n14, n15, n16;
        n14 = !a0;
        n12 = !(a1 || st[2]);
        n8  = n14 && st[1];
        n15 = n12 || n8;
        n16 = a3 || n8;
        n9  = !(n16 && n15);
        n11 = !(st[0] || n9);
        n10 = !(n14 || n11);
        n13 = !(a2 || n12);
        g17 = !n11;
        nx  = {n13, n11, n10};
    endfunction

    task automatic test_reset();
        RST = 1'b1;
        drive(1'b0, '0, '0, '0, '0);
        tick();
        tick();
        n_checks++;
        if (bus.STATE !== 12'h000) begin
            n_fail++; $display("FAIL reset_state: got %h want 000", bus.STATE);
        end
        n_checks++;
        if (bus.CYCLES !== 16'd0) begin
            n_fail++; $display("FAIL reset_cycles: got %0d want 0", bus.CYCLES);
        end
        n_checks++;
        if (bus.G17 !== 4'b1111) begin
            n_fail++; $display("FAIL reset_g17: got %b want 1111", bus.G17);
        end
        RST = 1'b0;
        drive(1'b1, '0, '0, '0, '0);
        for (int unsigned k = 1; k <= 3; k++) begin
            tick();
            n_checks++;
            if (bus.STATE !== 12'h000 || bus.CYCLES !== 16'(k)) begin
                n_fail++;
                $display("FAIL idle_run[%0d]: got state %h cycles %0d want 000 %0d",
                         k, bus.STATE, bus.CYCLES, k);
            end
        end
    endtask

    task automatic test_lane_seq();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        drive(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        #1;
        n_checks++;
        if (bus.G17 !== 4'b1110) begin
            n_fail++; $display("FAIL seq1_g17: got %b want 1110", bus.G17);
        end
        tick();
        n_checks++;
        if (bus.STATE !== 12'h002) begin
            n_fail++; $display("FAIL seq1_state: got %h want 002", bus.STATE);
        end
        drive(1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        #1;
        n_checks++;
        if (bus.G17 !== 4'b1111) begin
            n_fail++; $display("FAIL seq2_g17: got %b want 1111", bus.G17);
        end
        tick();
        n_checks++;
        if (bus.STATE !== 12'h005) begin
            n_fail++; $display("FAIL seq2_state: got %h want 005", bus.STATE);
        end
    endtask

    task automatic test_hold_isolation();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        drive(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        tick();
        drive(1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        tick();
        n_checks++;
        if (bus.STATE !== 12'h000 || bus.CYCLES !== 16'd0) begin
            n_fail++;
            $display("FAIL hold: got state %h cycles %0d want 000 0", bus.STATE, bus.CYCLES);
        end
        drive(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
        tick();
        n_checks++;
        if (bus.STATE !== 12'h080 || bus.CYCLES !== 16'd1) begin
            n_fail++;
            $display("FAIL isolation: got state %h cycles %0d want 080 1", bus.STATE, bus.CYCLES);
        end
    endtask

    task automatic test_midrun_reset();
        drive(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
        tick();
        n_checks++;
        if (bus.STATE !== 12'h492) begin
            n_fail++; $display("FAIL pre_reset_state: got %h want 492", bus.STATE);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        n_checks++;
        if (bus.STATE !== 12'h000 || bus.CYCLES !== 16'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: got state %h cycles %0d want 000 0", bus.STATE, bus.CYCLES);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_c [5];
        exp_c = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        RST2 = 1'b1;
        tick();
        RST2 = 1'b0;
        bus2.EN = 1'b1;
        for (int unsigned k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (bus2.CYCLES !== exp_c[k]) begin
                n_fail++;
                $display("FAIL saturate[%0d]: got %0d want %0d", k, bus2.CYCLES, exp_c[k]);
            end
        end
        RST2 = 1'b1;
        tick();
        RST2 = 1'b0;
        n_checks++;
        if (bus2.CYCLES !== 2'd0 || bus2.STATE !== 3'b000) begin
            n_fail++;
            $display("FAIL sat_reset: got cycles %0d state %b want 0 000", bus2.CYCLES, bus2.STATE);
        end
    endtask

`ifdef SCAN_CHAIN_EN
    task automatic test_scan();
        logic [11:0] pat;
        pat = 12'b1011_0100_1101;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        drive(1'b1, '0, '0, '0, '0);
        bus.SE = 1'b1;
        for (int unsigned k = 0; k < 12; k++) begin
            bus.SI = pat[11-k];
            tick();
        end
        n_checks++;
        if (bus.STATE !== pat || bus.CYCLES !== 16'd0) begin
            n_fail++;
            $display("FAIL scan_load: got state %b cycles %0d want %b 0", bus.STATE, bus.CYCLES, pat);
        end
        bus.SI = 1'b0;
        for (int unsigned k = 0; k < 12; k++) begin
            n_checks++;
            if (bus.SO !== pat[11-k]) begin
                n_fail++; $display("FAIL scan_out[%0d]: got %b want %b", k, bus.SO, pat[11-k]);
            end
            tick();
        end
        bus.SE = 1'b0;
    endtask
`endif

    task automatic test_random();
        bit [2:0] m_st [LANES];
        bit [3:0] m_g17;
        bit [2:0] nx;
        bit [11:0] m_state;
        int unsigned m_cyc;
        logic [3:0] r0, r1, r2, r3;
        logic ren, rrst;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int l = 0; l < LANES; l++) m_st[l] = '0;
        m_cyc = 0;
        for (int unsigned c = 0; c < 10000; c++) begin
            r0 = 4'($urandom); r1 = 4'($urandom); r2 = 4'($urandom); r3 = 4'($urandom);
            ren  = 1'($urandom);
            rrst = ($urandom_range(0, 31) == 0);
            RST = rrst;
            drive(ren, r0, r1, r2, r3);
            #1;
            for (int l = 0; l < LANES; l++) begin
                ref_s27(r0[l], r1[l], r2[l], r3[l], m_st[l], m_g17[l], nx);
                if (rrst) m_st[l] = '0;
                else if (ren) m_st[l] = nx;
            end
            n_checks++;
            if (bus.G17 !== m_g17) begin
                n_fail++; $display("FAIL rand_g17[%0d]: got %b want %b", c, bus.G17, m_g17);
            end
            if (rrst) m_cyc = 0;
            else if (ren && m_cyc < 65535) m_cyc++;
            tick();
            m_state = {m_st[3], m_st[2], m_st[1], m_st[0]};
            n_checks++;
            if (bus.STATE !== m_state) begin
                n_fail++; $display("FAIL rand_state[%0d]: got %h want %h", c, bus.STATE, m_state);
            end
            n_checks++;
            if (bus.CYCLES !== 16'(m_cyc)) begin
                n_fail++; $display("FAIL rand_cycles[%0d]: got %0d want %0d", c, bus.CYCLES, m_cyc);
            end
        end
        RST = 1'b0;
    endtask

    initial begin
        drive(1'b0, '0, '0, '0, '0);
        bus2.EN = 1'b0;
        bus2.G0 = '0;
        bus2.G1 = '0;
        bus2.G2 = '0;
        bus2.G3 = '0;
`ifdef SCAN_CHAIN_EN
        bus.SE  = 1'b0;
        bus.SI  = 1'b0;
        bus2.SE = 1'b0;
        bus2.SI = 1'b0;
`endif
        test_reset();
        test_lane_seq();
        test_hold_isolation();
        test_midrun_reset();
        test_saturation();
`ifdef SCAN_CHAIN_EN
        test_scan();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/s27_multi.md
# s27_multi

Parametrised, multi-lane successor to the ISCAS-89 s27 sequential benchmark. `LANES` independent copies of the s27 next-state/output logic share one clock and one synchronous reset. The block adds three things: a synchronous reset, a global hold enable and a saturating enabled-cycle counter. An optional scan chain is compiled in by macro. It serves as a scalable sequential workload for the benchmark suite, with deterministic reset, so encrypted and plaintext runs can be compared cycle by cycle.

## Interface
Parameters:
- `LANES`, 4: number of independent s27 lanes (≥1).
- `CNT_W`, 16: width of the enabled-cycle counter (≥2).

Ports:
- `CK`  in  1  clock; all flops sample on the rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `EN`  in  1  global state-advance enable; 0 holds all lane state.
- `G0`, `G1`, `G2`, `G3`  in  LANES each  per-lane primary inputs; bit i drives lane i.
- `G17`  out  LANES  per-lane primary output; combinational, as in s27.
- `STATE`  out  3*LANES  registered lane state; lane i occupies bits [3i+2:3i] = {G7,G6,G5}.
- `CYCLES`  out  CNT_W  count of enabled functional cycles since reset.
- `SE`, `SI`, `SO`: scan enable in 1, scan in in 1, scan out out 1. Present only when `SCAN_CHAIN_EN` is defined; see Configuration.

## Operation
- Lane state is three flops: G5, G6, G7.
- Per-lane combinational logic, with exact s27 semantics:
  - G14 = ~G0
  - G12 = ~(G1|G7)
  - G8 = G14&G6
  - G15 = G12|G8
  - G16 = G3|G8
  - G9 = ~(G16&G15)
  - G11 = ~(G5|G9)
  - G10 = ~(G14|G11)
  - G13 = ~(G2|G12)
  - G17 = ~G11
- Next state: G5←G10, G6←G11, G7←G13.
- Priority per edge is RST > SE (scan builds only) > EN > hold.
  - RST=1: all state and `CYCLES` go to 0.
  - EN=1: every lane loads its next state.
  - EN=0: every lane holds its state.
- Lanes never interact. Lane i uses only bit i of each input.
- `CYCLES` increments on each edge with RST=0, EN=1 and SE=0. It saturates at 2^CNT_W−1 and does not wrap.
- Reset values:
  - `STATE`=0, `CYCLES`=0.
  - `G17` is combinational; with state 0 it equals ~(G3 & ~G1) per lane.
  - `SO`=0.

## Timing
- `G17` has zero-cycle latency from the inputs and from the current state. There is no output register, matching s27.
- State update latency is one cycle: inputs present before edge k appear in `STATE` after edge k.
- RST asserted mid-run takes effect at the next edge, regardless of EN and SE. Inputs during reset are ignored for state, but `G17` still reflects them combinationally.
- Releasing RST with EN=1 advances state on the first edge after release.
- Simultaneous EN=1 and SE=1: the scan shift wins and `CYCLES` does not increment.

## Configuration
- `SCAN_CHAIN_EN` defined:
  - Ports `SE`, `SI` and `SO` exist.
  - The chain order is lane0 G5, G6, G7, then lane1 G5, G6, G7, … up to lane LANES−1 G7.
  - With SE=1 each edge shifts one position: `SI` enters lane0 G5, and `SO` = lane LANES−1 G7 (registered).
  - Scan length is 3*LANES.
- `SCAN_CHAIN_EN` undefined: no `SE`, `SI` or `SO` ports, no scan muxes, and behaviour is identical to the defined build with SE tied to 0.

## Structure
- Package `s27_multi_pkg`:
  - `S27_STATE_W` = 3.
  - Lane-state packed typedef with fields g7, g6, g5.
  - Reset-state constant (all zero).
- Sub-module `s27_lane`:
  - Contents: one lane's combinational logic plus its three flops, with RST, EN and (under the macro) scan mux, SI and SO pins.
  - Top level: instantiates `s27_lane` via generate, daisy-chains scan and owns `CYCLES`.

## Test plan
- **Reset and idle, LANES=4:** RST=1 for 2 cycles, all inputs 0 → `STATE`=0, `CYCLES`=0, `G17`=4'b1111. Release with EN=1 and inputs 0 → state stays 0, `CYCLES` increments by 1 per cycle.
- **Lane sequence, lane 0:**
  - From state 0 with G0=0, G1=0, G2=0, G3=1 → `G17`[0]=0 before the edge; next lane-0 state {G7,G6,G5}=3'b010.
  - Then G0=1, G1=1, G2=0, G3=0 → `G17`[0]=1; next state 3'b101.
- **Hold and isolation:** drive the lane-0 sequence while EN=0 → `STATE` and `CYCLES` unchanged. Drive only lane 2 with EN=1 → lanes 0, 1 and 3 stay 0.
- **Mid-run reset and saturation:**
  - CNT_W=2, EN=1 for 5 cycles → `CYCLES` reads 1, 2, 3, 3, 3.
  - Assert RST for one cycle mid-sequence → `STATE`=0 and `CYCLES`=0 on the next edge.
- **Scan (SCAN_CHAIN_EN, LANES=2):**
  - Shift in 6'b101101 over 6 cycles with SE=1, EN=1 → `STATE` holds the shifted pattern and `CYCLES` is unchanged.
  - Shift 6 more cycles → `SO` reproduces the pattern in order.
- **Random equivalence:** 10k random cycles with random EN and RST → every lane matches an independent s27 reference model bit-exactly on `G17` and `STATE`.
